jellyvl_etherneco_tx_scheduler: RTL

Shares the single outer-ring command transmitter (`jellyvl_etherneco_packet_tx`) of the EtherNeco master between several command sources, e.g. synctimer on channel 0 and register access on channels 1..N-1. It arbitrates requests, latches the winning header, issues the one-cycle `tx_start`, muxes the winner's payload stream, and waits for end of packet. It then enforces a programmable inter-packet gap before the next grant.

---
 rtl/jellyvl_etherneco_tx_scheduler_pkg.sv | 23 ++
 rtl/jellyvl_etherneco_rr_picker.sv | 35 +++
 rtl/jellyvl_etherneco_tx_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/jellyvl_etherneco_tx_scheduler_pkg.sv
// Shared types for the EtherNeco outer-ring TX scheduler.
//   sched_state_t : scheduler FSM states (also exported on the debug port)
//   tx_header_t   : header latched for the packet transmitter
//   SCHED_CH_MAX  : largest supported number of requester channels
package jellyvl_etherneco_tx_scheduler_pkg;

   localparam int SCHED_CH_MAX = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_WAIT_END = 3'd3,
      ST_GAP      = 3'd4
   } sched_state_t;

   typedef struct packed {
      logic [15:0] length;
      logic [7:0]  pkt_type;
      logic [7:0]  node;
   } tx_header_t;

endpackage

// File: rtl/jellyvl_etherneco_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : channel with the highest priority this round
//   grant : one-hot winner (first set request at or after ptr, wrapping)
//   valid : some request was set
module jellyvl_etherneco_rr_picker #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   output logic [NUM_CH-1:0]         grant,
   output logic                      valid
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [CH_W-1:0] idx;
   logic            found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = CH_W'((int'(ptr) + k) % NUM_CH);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign valid = found;

endmodule

// File: rtl/jellyvl_etherneco_tx_scheduler.sv
// Shares the single outer-ring packet transmitter between NUM_CH command
// sources. Channel 0 has absolute priority, channels 1..NUM_CH-1 share the
// remaining slots round-robin. After each packet a programmable idle gap is
// inserted before the next grant.
//   s_req / s_length / s_type / s_node : per-channel request and header
//   s_grant                            : one-cycle one-hot grant pulse
//   s_payload_* / m_payload_*          : payload stream, muxed from cur_ch
//   tx_start, tx_length/type/node      : start pulse and latched header
//   tx_end                             : last byte left the packet TX
//   gap_cycles                         : idle cycles after tx_end (sampled on tx_end)
//   busy, cur_ch, error                : status; error is sticky until reset
//   dbg_state                          : FSM state for observation
// Payload handshake: a byte transfers on a cycle where valid and ready are
// both high; valid must not depend on ready, and data/last are only
// meaningful while valid is high.
module jellyvl_etherneco_tx_scheduler
   import jellyvl_etherneco_tx_scheduler_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int GAP_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [GAP_WIDTH-1:0]      gap_cycles,
   input  logic [NUM_CH-1:0]         s_req,
   input  logic [NUM_CH*16-1:0]      s_length,
   input  logic [NUM_CH*8-1:0]       s_type,
   input  logic [NUM_CH*8-1:0]       s_node,
   output logic [NUM_CH-1:0]         s_grant,
   input  logic [NUM_CH-1:0]         s_payload_last,
   input  logic [NUM_CH-1:0]         s_payload_valid,
   input  logic [NUM_CH*8-1:0]       s_payload_data,
   output logic [NUM_CH-1:0]         s_payload_ready,
   output logic                      tx_start,
   output logic [15:0]               tx_length,
   output logic [7:0]                tx_type,
   output logic [7:0]                tx_node,
   output logic                      m_payload_last,
   output logic                      m_payload_valid,
   output logic [7:0]                m_payload_data,
   input  logic                      m_payload_ready,
   input  logic                      tx_end,
   output logic                      busy,
   output logic [$clog2(NUM_CH)-1:0] cur_ch,
   output logic                      error,
   output logic [2:0]                dbg_state
);

   localparam int CH_W = $clog2(NUM_CH);

   sched_state_t         state, state_next;
   tx_header_t           hdr;
   logic [CH_W-1:0]      rr_ptr;
   logic [GAP_WIDTH-1:0] gap_cnt;

   logic [15:0] len_arr  [NUM_CH];
   logic [7:0]  type_arr [NUM_CH];
   logic [7:0]  node_arr [NUM_CH];
   logic [7:0]  data_arr [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign len_arr[i]  = s_length[i*16 +: 16];
      assign type_arr[i] = s_type[i*8 +: 8];
      assign node_arr[i] = s_node[i*8 +: 8];
      assign data_arr[i] = s_payload_data[i*8 +: 8];
   end

   // Channel 0 is masked out of the round-robin; it wins outright below.
   logic [NUM_CH-1:0] rr_req, rr_grant;
   logic              rr_valid;
   logic [CH_W-1:0]   rr_idx;

   assign rr_req = {s_req[NUM_CH-1:1], 1'b0};

   jellyvl_etherneco_rr_picker #(
      .NUM_CH (NUM_CH)
   ) u_picker (
      .req   (rr_req),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .valid (rr_valid)
   );

   always_comb begin
      rr_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rr_grant[i]) rr_idx = CH_W'(i);
      end
   end

   logic            win_valid;
   logic [CH_W-1:0] win_idx;

   assign win_valid = s_req[0] | rr_valid;
   assign win_idx   = s_req[0] ? '0 : rr_idx;

   // tx_end in PAYLOAD always ends the packet; with no last handshake in
   // the same cycle it is also a protocol error.
   logic last_hs, end_exit, error_set;

   assign last_hs   = m_payload_valid & m_payload_ready & m_payload_last;
   assign end_exit  = tx_end & ((state == ST_WAIT_END) | (state == ST_PAYLOAD));
   assign error_set = tx_end & (((state == ST_PAYLOAD) & ~last_hs) |
                                (state == ST_IDLE) | (state == ST_START) |
                                (state == ST_GAP));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:     if (win_valid) state_next = ST_START;
         ST_START:    state_next = ST_PAYLOAD;
         ST_PAYLOAD: begin
            if (end_exit)     state_next = (gap_cycles == '0) ? ST_IDLE : ST_GAP;
            else if (last_hs) state_next = ST_WAIT_END;
         end
         ST_WAIT_END: if (end_exit) state_next = (gap_cycles == '0) ? ST_IDLE : ST_GAP;
         ST_GAP:      if (gap_cnt <= GAP_WIDTH'(1)) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_start        = (state == ST_START);
      busy            = (state != ST_IDLE);
      dbg_state       = state;
      s_grant         = '0;
      s_payload_ready = '0;
      m_payload_valid = 1'b0;
      m_payload_last  = 1'b0;
      m_payload_data  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (state == ST_START && cur_ch == CH_W'(i))   s_grant[i] = 1'b1;
         if (state == ST_PAYLOAD && cur_ch == CH_W'(i)) s_payload_ready[i] = m_payload_ready;
      end
      if (state == ST_PAYLOAD) begin
         m_payload_valid = s_payload_valid[cur_ch];
         m_payload_last  = s_payload_last[cur_ch];
         m_payload_data  = data_arr[cur_ch];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hdr     <= '0;
         cur_ch  <= '0;
         rr_ptr  <= CH_W'(1);
         gap_cnt <= '0;
         error   <= 1'b0;
      end else begin
         if (state == ST_IDLE && win_valid) begin
            hdr.length   <= len_arr[win_idx];
            hdr.pkt_type <= type_arr[win_idx];
            hdr.node     <= node_arr[win_idx];
            cur_ch       <= win_idx;
         end
         // Channel-0 grants leave the round-robin order untouched.
         if (state == ST_START && cur_ch != '0) begin
            rr_ptr <= (cur_ch == CH_W'(NUM_CH - 1)) ? CH_W'(1) : cur_ch + CH_W'(1);
         end
         if (end_exit)              gap_cnt <= gap_cycles;
         else if (state == ST_GAP)  gap_cnt <= gap_cnt - GAP_WIDTH'(1);
         if (error_set) error <= 1'b1;
      end
   end

   assign tx_length = hdr.length;
   assign tx_type   = hdr.pkt_type;
   assign tx_node   = hdr.node;

endmodule
